// File: rtl/control_sequencer.sv
// Control-unit stepper and instruction decode: a one-hot 7-step sequencer that
// turns the current step, instruction word and ALU flags into bus enable/set strobes.
module control_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic [3:0] flags,
    output logic [6:0] step,
    output logic       bus1,
    output logic       iar_e,
    output logic       iar_s,
    output logic       mar_s,
    output logic       ram_e,
    output logic       ram_s,
    output logic       acc_e,
    output logic       acc_s,
    output logic       tmp_s,
    output logic       flags_s,
    output logic       ir_s,
    output logic [3:0] reg_e,
    output logic [3:0] reg_s,
    output logic [2:0] alu_op
);

    // state | meaning
    // S1    | fetch: IAR to MAR, ACC = IAR + 1
    // S2    | fetch: RAM to IR
    // S3    | fetch: ACC to IAR
    // S4    | execute step 1 (opcode dependent)
    // S5    | execute step 2 (opcode dependent)
    // S6    | execute step 3 (opcode dependent)
    // S7    | idle, wraps to S1
    typedef enum logic [6:0] {
        S1 = 7'b0000001,
        S2 = 7'b0000010,
        S3 = 7'b0000100,
        S4 = 7'b0001000,
        S5 = 7'b0010000,
        S6 = 7'b0100000,
        S7 = 7'b1000000
    } step_t;

    step_t state, state_nxt;
    logic [3:0] ra_oh, rb_oh;

    assign ra_oh = 4'b0001 << ir[3:2];
    assign rb_oh = 4'b0001 << ir[1:0];
    assign step  = state;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S1;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus1      = 1'b0;
        iar_e     = 1'b0;
        iar_s     = 1'b0;
        mar_s     = 1'b0;
        ram_e     = 1'b0;
        ram_s     = 1'b0;
        acc_e     = 1'b0;
        acc_s     = 1'b0;
        tmp_s     = 1'b0;
        flags_s   = 1'b0;
        ir_s      = 1'b0;
        reg_e     = 4'b0000;
        reg_s     = 4'b0000;
        alu_op    = 3'b000;

        if (run) begin
            case (state)
                S1:      state_nxt = S2;
                S2:      state_nxt = S3;
                S3:      state_nxt = S4;
                S4:      state_nxt = S5;
                S5:      state_nxt = S6;
                S6:      state_nxt = S7;
                S7:      state_nxt = S1;
                default: state_nxt = S1;
            endcase
        end

        // Strobes are gated off entirely while held in reset or frozen.
        if (reset_n && run) begin
            case (state)
                S1: begin bus1 = 1'b1; iar_e = 1'b1; mar_s = 1'b1; acc_s = 1'b1; end
                S2: begin ram_e = 1'b1; ir_s = 1'b1; end
                S3: begin acc_e = 1'b1; iar_s = 1'b1; end
                S4: begin
                    if (ir[7]) begin
                        reg_e = rb_oh; tmp_s = 1'b1;
                    end else begin
                        case (ir[6:4])
                            3'b000, 3'b001: begin reg_e = ra_oh; mar_s = 1'b1; end
                            3'b010, 3'b101: begin bus1 = 1'b1; iar_e = 1'b1; mar_s = 1'b1; acc_s = 1'b1; end
                            3'b011:         begin reg_e = rb_oh; iar_s = 1'b1; end
                            3'b100:         begin iar_e = 1'b1; mar_s = 1'b1; end
                            3'b110:         begin bus1 = 1'b1; flags_s = 1'b1; end
                            default:        ;
                        endcase
                    end
                end
                S5: begin
                    if (ir[7]) begin
                        reg_e = ra_oh; alu_op = ir[6:4]; acc_s = 1'b1; flags_s = 1'b1;
                    end else begin
                        case (ir[6:4])
                            3'b000, 3'b010: begin ram_e = 1'b1; reg_s = rb_oh; end
                            3'b001:         begin reg_e = rb_oh; ram_s = 1'b1; end
                            3'b100:         begin ram_e = 1'b1; iar_s = 1'b1; end
                            3'b101:         begin acc_e = 1'b1; iar_s = 1'b1; end
                            default:        ;
                        endcase
                    end
                end
                S6: begin
                    if (ir[7]) begin
                        acc_e = 1'b1;
                        if (ir[6:4] != 3'b111) reg_s = rb_oh;
                    end else begin
                        case (ir[6:4])
                            3'b010: begin acc_e = 1'b1; iar_s = 1'b1; end
                            3'b101: begin ram_e = 1'b1; iar_s = |(ir[3:0] & flags); end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
